// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer:
//   - fetch_state_e : FSM state encoding (IDLE, REQ, HOLD, STEP, SETTLE)
//   - STROBE_ACTIVE / STROBE_IDLE : levels of the active-low counter strobes
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    HOLD   = 3'd2,
    STEP   = 3'd3,
    SETTLE = 3'd4
  } fetch_state_e;

  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic STROBE_IDLE   = 1'b1;

endpackage

// File: rtl/fetch_seq.sv
// -----------------------------------------------------------------------------
// fetch_seq
// Instruction-fetch sequencer driving an external up-counter program counter.
// One fetch: capture pc_q and request memory, latch the word into ir, wait for
// decode to accept it, pulse exactly one counter strobe (load on redirect,
// increment otherwise), then give the counter a cycle to settle.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   clear      : synchronous active-low reset
//   halt       : blocks the start of a new fetch (looked at only in IDLE)
//   pc_q       : current counter value
//   pc_inc     : active-low increment strobe to the counter (idle high)
//   pc_load    : active-low load strobe to the counter (idle high)
//   pc_d       : load value presented to the counter
//   mem_req    : instruction-memory read request
//   mem_addr   : read address, pc_q captured at request start
//   mem_ack    : memory completion, mem_data valid in the same cycle
//   mem_data   : instruction word from memory
//   ir         : registered instruction
//   ir_valid   : ir holds an unconsumed instruction
//   ir_ready   : decode accepts ir when ir_valid and ir_ready are both high
//   br_valid   : redirect request, sampled only in the accept cycle
//   br_target  : redirect address
// -----------------------------------------------------------------------------
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         halt,
  input  logic [N-1:0] pc_q,
  output logic         pc_inc,
  output logic         pc_load,
  output logic [N-1:0] pc_d,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_data,
  output logic [W-1:0] ir,
  output logic         ir_valid,
  input  logic         ir_ready,
  input  logic         br_valid,
  input  logic [N-1:0] br_target
);

  fetch_state_e state_r, state_s;
  logic         pc_inc_r, pc_inc_s;
  logic         pc_load_r, pc_load_s;
  logic [N-1:0] pc_d_r, pc_d_s;
  logic         mem_req_r, mem_req_s;
  logic [N-1:0] mem_addr_r, mem_addr_s;
  logic [W-1:0] ir_r, ir_s;
  logic         ir_valid_r, ir_valid_s;

  // Next-state and next-output logic; every output is registered, so the
  // strobe chosen on the accept edge is low for exactly the STEP cycle.
  always_comb begin
    state_s    = state_r;
    pc_inc_s   = STROBE_IDLE;
    pc_load_s  = STROBE_IDLE;
    pc_d_s     = pc_d_r;
    mem_req_s  = mem_req_r;
    mem_addr_s = mem_addr_r;
    ir_s       = ir_r;
    ir_valid_s = ir_valid_r;

    case (state_r)
      IDLE: begin
        if (!halt) begin
          state_s    = REQ;
          mem_req_s  = 1'b1;
          mem_addr_s = pc_q;
        end else begin
          state_s    = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_s    = HOLD;
          mem_req_s  = 1'b0;
          ir_s       = mem_data;
          ir_valid_s = 1'b1;
        end else begin
          state_s    = REQ;
        end
      end
      HOLD: begin
        if (ir_valid_r && ir_ready) begin
          state_s    = STEP;
          ir_valid_s = 1'b0;
          // Redirect is decided here, in the accept cycle only.
          if (br_valid) begin
            pc_d_s    = br_target;
            pc_load_s = STROBE_ACTIVE;
          end else begin
            pc_inc_s  = STROBE_ACTIVE;
          end
        end else begin
          state_s    = HOLD;
        end
      end
      STEP: begin
        // Strobes fall back to idle by default; SETTLE lets pc_q update.
        state_s = SETTLE;
      end
      SETTLE: begin
        state_s = IDLE;
      end
      default: begin
        state_s    = IDLE;
        mem_req_s  = 1'b0;
        ir_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_r    <= IDLE;
      pc_inc_r   <= STROBE_IDLE;
      pc_load_r  <= STROBE_IDLE;
      pc_d_r     <= {N{1'b0}};
      mem_req_r  <= 1'b0;
      mem_addr_r <= {N{1'b0}};
      ir_r       <= {W{1'b0}};
      ir_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_inc_r   <= pc_inc_s;
      pc_load_r  <= pc_load_s;
      pc_d_r     <= pc_d_s;
      mem_req_r  <= mem_req_s;
      mem_addr_r <= mem_addr_s;
      ir_r       <= ir_s;
      ir_valid_r <= ir_valid_s;
    end
  end

  assign pc_inc   = pc_inc_r;
  assign pc_load  = pc_load_r;
  assign pc_d     = pc_d_r;
  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;
  assign ir       = ir_r;
  assign ir_valid = ir_valid_r;

endmodule

// File: tb/tb_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_fetch_seq
// Environment for fetch_seq: a behavioural up-counter, a memory responder and
// a decode sink drive the DUT; they push expected fetch addresses, words,
// handshake lengths and strobe kinds into queues, and a monitor pops and
// compares them whenever the DUT presents the matching output.
// -----------------------------------------------------------------------------
module tb_fetch_seq;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clear;
  logic         halt;
  logic [N-1:0] pc_q = '0;
  logic         pc_inc;
  logic         pc_load;
  logic [N-1:0] pc_d;
  logic         mem_req;
  logic [N-1:0] mem_addr;
  logic         mem_ack;
  logic [W-1:0] mem_data;
  logic [W-1:0] ir;
  logic         ir_valid;
  logic         ir_ready;
  logic         br_valid;
  logic [N-1:0] br_target;

  fetch_seq #(.N(N), .W(W)) dut (
    .clk(clk), .clear(clear), .halt(halt), .pc_q(pc_q),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_d(pc_d),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_valid(br_valid), .br_target(br_target)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic empty_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: expectation queue empty (t=%0t)", nm, $time);
  endtask

  // ---------------- external counter (environment) ----------------
  logic         preset_en  = 1'b0;
  logic [N-1:0] preset_val = '0;
  always @(posedge clk) begin
    if (preset_en)            pc_q <= preset_val;
    else if (pc_load == 1'b0) pc_q <= pc_d;
    else if (pc_inc == 1'b0)  pc_q <= pc_q + 1'b1;
  end

  // ---------------- scoreboard queues and reference model ----------------
  typedef struct packed { logic ld; logic [N-1:0] pcd; } strobe_t;
  logic [N-1:0] exp_addr_q[$];
  logic [W-1:0] exp_ir_q[$];
  int           exp_reqlen_q[$];
  int           exp_holdlen_q[$];
  strobe_t      exp_strobe_q[$];

  logic [N-1:0] model_pc = '0;
  logic [N-1:0] model_last_load = '0;

  int           cfg_ack = -1, cfg_ready = -1, cfg_br = -1, cfg_data = -1, cfg_stray = 0;
  logic [N-1:0] cfg_target = '0;
  bit           sb_en = 1'b0;

  int           rise_cnt = 0;
  int           last_rise = -1;
  int           last_period = 0;
  logic [N-1:0] last_req_addr = '0;

  // ---------------- memory responder ----------------
  initial begin : mem_drv
    bit seen;
    int left;
    seen = 1'b0; left = 0; mem_ack = 1'b0; mem_data = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          left = (cfg_ack < 0) ? $urandom_range(0, 3) : cfg_ack;
          if (sb_en) exp_reqlen_q.push_back(left + 1);
        end
        if (left == 0) begin
          mem_ack  = 1'b1;
          mem_data = (cfg_data < 0) ? W'($urandom) : W'(cfg_data);
          if (sb_en) exp_ir_q.push_back(mem_data);
        end else begin
          mem_ack  = 1'b0;
          mem_data = W'($urandom);
          left--;
        end
      end else begin
        seen     = 1'b0;
        mem_ack  = (cfg_stray == 1) ? 1'b1 :
                   (cfg_stray == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_data = W'($urandom);
      end
    end
  end

  // ---------------- decode sink ----------------
  initial begin : dec_drv
    bit      seen;
    int      left;
    bit      take_br;
    strobe_t s;
    seen = 1'b0; left = 0; ir_ready = 1'b0; br_valid = 1'b0; br_target = '0;
    forever begin
      @(negedge clk);
      if (ir_valid === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          left = (cfg_ready < 0) ? $urandom_range(0, 3) : cfg_ready;
          if (sb_en) exp_holdlen_q.push_back(left + 1);
        end
        if (left == 0) begin
          ir_ready  = 1'b1;
          take_br   = (cfg_br < 0) ? 1'($urandom_range(0, 1)) : (cfg_br != 0);
          br_valid  = take_br;
          br_target = (cfg_br < 0) ? N'($urandom) : cfg_target;
          if (sb_en) begin
            // next fetch address: redirect target, or previous address + 1 mod 2^N
            if (take_br) begin
              model_last_load = br_target;
              model_pc        = br_target;
            end else begin
              model_pc = N'((int'(model_pc) + 1) % (1 << N));
            end
            s.ld  = take_br;
            s.pcd = model_last_load;
            exp_strobe_q.push_back(s);
            exp_addr_q.push_back(model_pc);
          end
        end else begin
          ir_ready  = 1'b0;
          br_valid  = 1'($urandom_range(0, 1));
          br_target = N'($urandom);
          left--;
        end
      end else begin
        seen      = 1'b0;
        ir_ready  = 1'($urandom_range(0, 1));
        br_valid  = 1'($urandom_range(0, 1));
        br_target = N'($urandom);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : mon
    logic         prev_req, prev_iv;
    logic [N-1:0] held_addr;
    logic [W-1:0] held_ir;
    int           req_len, hold_len, cyc;
    strobe_t      s;
    prev_req = 1'b0; prev_iv = 1'b0; held_addr = '0; held_ir = '0;
    req_len = 0; hold_len = 0; cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_req === 1'b1 && prev_req !== 1'b1) begin
        rise_cnt++;
        if (last_rise >= 0) last_period = cyc - last_rise;
        last_rise     = cyc;
        last_req_addr = mem_addr;
      end
      if (sb_en) begin
        check("strobe_excl", 32'(pc_inc | pc_load), 32'd1);
        // request channel
        if (mem_req && !prev_req) begin
          if (exp_addr_q.size() == 0) empty_fail("mem_addr");
          else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
          held_addr = mem_addr;
          req_len   = 1;
        end else if (mem_req && prev_req) begin
          check("addr_stable", 32'(mem_addr), 32'(held_addr));
          req_len++;
        end else if (!mem_req && prev_req) begin
          if (exp_reqlen_q.size() == 0) empty_fail("req_len");
          else check("req_len", 32'(req_len), 32'(exp_reqlen_q.pop_front()));
        end
        // instruction channel
        if (ir_valid && !prev_iv) begin
          if (exp_ir_q.size() == 0) empty_fail("ir");
          else check("ir", 32'(ir), 32'(exp_ir_q.pop_front()));
          held_ir  = ir;
          hold_len = 1;
        end else if (ir_valid && prev_iv) begin
          check("ir_stable", 32'(ir), 32'(held_ir));
          hold_len++;
        end else if (!ir_valid && prev_iv) begin
          if (exp_holdlen_q.size() == 0) empty_fail("hold_len");
          else check("hold_len", 32'(hold_len), 32'(exp_holdlen_q.pop_front()));
        end
        // strobes: exactly one low in the cycle right after accept, else both high
        if (!ir_valid && prev_iv) begin
          if (exp_strobe_q.size() == 0) empty_fail("strobe");
          else begin
            s = exp_strobe_q.pop_front();
            check("pc_load_step", 32'(pc_load), s.ld ? 32'd0 : 32'd1);
            check("pc_inc_step",  32'(pc_inc),  s.ld ? 32'd1 : 32'd0);
            check("pc_d",         32'(pc_d),    32'(s.pcd));
          end
        end else begin
          check("strobe_idle", 32'({pc_inc, pc_load}), 32'd3);
        end
      end
      prev_req = mem_req;
      prev_iv  = ir_valid;
    end
  end

  // ---------------- main sequence helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_rises(input int target, input int budget);
    int k;
    k = 0;
    while (rise_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (rise_cnt < target) begin
      errors++;
      $display("FAIL wait_rises: got %0d requests expected %0d (timeout)", rise_cnt, target);
    end
  endtask

  task automatic preset(input logic [N-1:0] v);
    preset_val = v;
    preset_en  = 1'b1;
    tick(1);
    preset_en  = 1'b0;
    exp_addr_q.delete();
    exp_addr_q.push_back(v);
    model_pc = v;
  endtask

  task automatic drain();
    halt = 1'b1;
    tick(30);
    check("left_ir",     32'(exp_ir_q.size()),      32'd0);
    check("left_strobe", 32'(exp_strobe_q.size()),  32'd0);
    check("left_len",    32'(exp_reqlen_q.size() + exp_holdlen_q.size()), 32'd0);
    check("left_addr",   32'(exp_addr_q.size()),    32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_inc"},   32'(pc_inc),   32'd1);
    check({tag, "_pc_load"},  32'(pc_load),  32'd1);
    check({tag, "_pc_d"},     32'(pc_d),     32'd0);
    check({tag, "_mem_req"},  32'(mem_req),  32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int start, k;
    clear = 1'b0;
    halt  = 1'b1;
    tick(2);
    check_reset_outputs("rst");
    check("rst_ir", 32'(ir), 32'd0);
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("halt_idle", 32'(mem_req), 32'd0);
    end

    // immediate ack/ready, increment, fixed word
    preset(4'd3);
    cfg_ack = 0; cfg_ready = 0; cfg_br = 0; cfg_data = 8'hA5; cfg_stray = 0;
    sb_en = 1'b1;
    start = rise_cnt;
    halt  = 1'b0;
    wait_rises(start + 2, 40);
    check("period", 32'(last_period), 32'd5);
    drain();

    // delayed ack (3) and delayed ready (2)
    cfg_ack = 3; cfg_ready = 2; cfg_data = -1;
    start = rise_cnt;
    halt  = 1'b0;
    wait_rises(start + 2, 60);
    drain();

    // redirect to 4'hC, then an increment fetch keeps pc_d
    cfg_ack = 0; cfg_ready = 0; cfg_br = 1; cfg_target = 4'hC;
    start = rise_cnt;
    halt  = 1'b0;
    wait_rises(start + 2, 40);
    check("br_next_addr", 32'(last_req_addr), 32'hC);
    cfg_br = 0;
    drain();
    check("pc_d_hold", 32'(pc_d), 32'hC);

    // wrap from 4'hF
    preset(4'hF);
    start = rise_cnt;
    halt  = 1'b0;
    wait_rises(start + 2, 40);
    check("wrap_addr", 32'(last_req_addr), 32'd0);
    drain();

    // randomized traffic with halt noise and stray acks
    cfg_ack = -1; cfg_ready = -1; cfg_br = -1; cfg_stray = 2;
    for (int i = 0; i < 400; i++) begin
      halt = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    cfg_stray = 0;
    drain();

    // clear while in REQ
    sb_en = 1'b0;
    cfg_ack = 50; cfg_ready = 0; cfg_br = 0;
    halt = 1'b0;
    k = 0;
    while (mem_req !== 1'b1 && k < 20) begin tick(1); k++; end
    check("req_reached", 32'(mem_req), 32'd1);
    tick(1);
    clear = 1'b0;
    halt  = 1'b1;
    tick(1);
    check_reset_outputs("rst_req");
    clear     = 1'b1;
    cfg_stray = 1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("stray_req", 32'(mem_req),  32'd0);
      check("stray_ir",  32'({ir_valid, ir}), 32'd0);
    end
    cfg_stray = 0;
    cfg_ack   = 0;
    halt      = 1'b0;
    tick(1);
    check("idle_after_rst", 32'(mem_req), 32'd1);

    // clear while in STEP
    k = 0;
    while (pc_inc !== 1'b0 && k < 30) begin tick(1); k++; end
    check("step_reached", 32'(pc_inc), 32'd0);
    clear = 1'b0;
    halt  = 1'b1;
    tick(1);
    check_reset_outputs("rst_step");
    clear = 1'b1;
    tick(3);
    check("post_step_idle", 32'(mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter N, default 4, width of the program-counter address.
REQ-002 Parameter W, default 8, width of the instruction word.
REQ-003 Port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 Port clear, input, 1, synchronous active-low reset.
REQ-005 Port halt, input, 1, high blocks the start of a new fetch.
REQ-006 Port pc_q, input, N, current value of the downstream up-counter.
REQ-007 Port pc_inc, output, 1, active-low increment strobe to the counter; idle high.
REQ-008 Port pc_load, output, 1, active-low load strobe to the counter; idle high.
REQ-009 Port pc_d, output, N, load value presented to the counter.
REQ-010 Port mem_req, output, 1, instruction-memory read request.
REQ-011 Port mem_addr, output, N, read address; equals pc_q captured at request start.
REQ-012 Port mem_ack, input, 1, memory completion; mem_data valid in the same cycle.
REQ-013 Port mem_data, input, W, instruction word from memory.
REQ-014 Port ir, output, W, registered instruction.
REQ-015 Port ir_valid, output, 1, ir holds an unconsumed instruction.
REQ-016 Port ir_ready, input, 1, decode accepts ir when ir_valid and ir_ready are both high.
REQ-017 Port br_valid, input, 1, redirect request; sampled only in the accept cycle.
REQ-018 Port br_target, input, N, redirect address.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, HOLD, STEP and SETTLE.
REQ-020 IDLE SHALL go to REQ when halt=0, capturing pc_q into mem_addr and setting mem_req=1 on that edge.
REQ-021 REQ SHALL hold mem_req=1 and mem_addr stable until mem_ack=1, then latch mem_data into ir, set ir_valid=1, clear mem_req and enter HOLD.
REQ-022 mem_ack SHALL be ignored in every state other than REQ.
REQ-023 HOLD SHALL keep ir and ir_valid stable until ir_valid and ir_ready are both high, then clear ir_valid and enter STEP.
REQ-024 In the accept cycle, br_valid=1 SHALL register pc_d=br_target and select a load step; br_valid=0 SHALL select an increment step.
REQ-025 STEP SHALL drive exactly one strobe low (pc_load or pc_inc, per REQ-024) for exactly one cycle, then enter SETTLE.
REQ-026 pc_inc and pc_load SHALL never be low in the same cycle.
REQ-027 SETTLE SHALL drive both strobes high for one cycle so the counter output settles, then enter IDLE.
REQ-028 Minimum fetch-to-fetch period SHALL be 5 cycles (IDLE, REQ with immediate ack, HOLD with immediate ready, STEP, SETTLE).
REQ-029 halt SHALL be sampled only in IDLE; a fetch already started SHALL complete through SETTLE.
REQ-030 Address wrap (pc_q = 2^N-1 followed by an increment) SHALL need no special handling; the next fetch uses address 0.
REQ-031 pc_d SHALL hold its last load value when no load is pending.

Reset
REQ-032 When clear=0 at a rising edge: state=IDLE, pc_inc=1, pc_load=1, pc_d=0, mem_req=0, mem_addr=0, ir=0, ir_valid=0.
REQ-033 Reset SHALL override any state, including mid-REQ (request dropped without waiting for ack) and mid-STEP (strobe returns high).
REQ-034 The counter's own clear is driven outside this block; fetch_seq SHALL NOT drive it.

Structure
REQ-035 The state encoding and strobe-level constants (STROBE_ACTIVE=0, STROBE_IDLE=1) SHALL live in the shared package fetch_pkg.
REQ-036 The design SHALL be a single module with no sub-module; the ir register stays inline.

Verification
REQ-037 Scenario: clear=0 for 2 cycles, then 1 -> all outputs at reset values; with halt=1 the FSM stays in IDLE and mem_req stays 0.
REQ-038 Scenario: pc_q=3, halt=0, mem_ack the cycle after mem_req rises with mem_data=8'hA5, ir_ready=1 -> mem_addr=3, ir=8'hA5, one-cycle pc_inc low, pc_load stays high, 5-cycle period.
REQ-039 Scenario: ack delayed 3 cycles and ir_ready delayed 2 cycles -> mem_req high 4 cycles with mem_addr stable; ir_valid high 3 cycles; no strobe until accept.
REQ-040 Scenario: accept with br_valid=1, br_target=4'hC -> pc_d=4'hC, one-cycle pc_load low, pc_inc stays high; the next fetch uses mem_addr=4'hC.
REQ-041 Scenario: pc_q=4'hF, increment step, counter wraps -> the next mem_addr=0.
REQ-042 Scenario: clear=0 asserted in REQ, and separately in STEP -> next cycle mem_req=0, both strobes high, state IDLE; a stray mem_ack in IDLE has no effect.
